// File: rtl/ir_pkg.sv
// ir_pkg: MIPS32 instruction field layout and widths
// shared by the instruction queue and decode logic.
package ir_pkg;

  localparam int INST_W = 32;
  localparam int EXT_W  = 32;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;
  localparam int IM_HI = 15;
  localparam int IM_LO = 0;
  localparam int AD_HI = 25;
  localparam int AD_LO = 0;

  localparam int OP_W   = OP_HI - OP_LO + 1;
  localparam int REG_W  = RS_HI - RS_LO + 1;
  localparam int SH_W   = SH_HI - SH_LO + 1;
  localparam int FN_W   = FN_HI - FN_LO + 1;
  localparam int IMM_W  = IM_HI - IM_LO + 1;
  localparam int ADDR_W = AD_HI - AD_LO + 1;

  function automatic logic [EXT_W-1:0] sext_imm(
    input logic [IMM_W-1:0] v
  );
    return {{(EXT_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [EXT_W-1:0] zext_imm(
    input logic [IMM_W-1:0] v
  );
    return {{(EXT_W-IMM_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// ir_field_decode: splits a MIPS32 word into fields and extended
// immediates; every output is 0 while valid is low.
module ir_field_decode
  import ir_pkg::*;
(
  input  logic [INST_W-1:0] word,
  input  logic              valid,
  output logic [OP_W-1:0]   op_code,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  rd,
  output logic [SH_W-1:0]   shamt,
  output logic [FN_W-1:0]   func,
  output logic [IMM_W-1:0]  imm16,
  output logic [EXT_W-1:0]  imm32_s,
  output logic [EXT_W-1:0]  imm32_z,
  output logic [ADDR_W-1:0] addr26
);

  // Masking the word once zeroes every derived field together.
  logic [INST_W-1:0] w;

  assign w = valid ? word : '0;

  assign op_code = w[OP_HI:OP_LO];
  assign rs      = w[RS_HI:RS_LO];
  assign rt      = w[RT_HI:RT_LO];
  assign rd      = w[RD_HI:RD_LO];
  assign shamt   = w[SH_HI:SH_LO];
  assign func    = w[FN_HI:FN_LO];
  assign imm16   = w[IM_HI:IM_LO];
  assign addr26  = w[AD_HI:AD_LO];
  assign imm32_s = sext_imm(imm16);
  assign imm32_z = zext_imm(imm16);

endmodule

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction/PC queue with valid/ready
// handshake, flush, and a pre-decoded head entry.
module ir_queue
  import ir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [INST_W-1:0]          Data,
  input  logic [PC_W-1:0]            PC_In,
  input  logic                       Flush,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [OP_W-1:0]            OP_Code,
  output logic [REG_W-1:0]           Rs,
  output logic [REG_W-1:0]           Rt,
  output logic [REG_W-1:0]           Rd,
  output logic [SH_W-1:0]            Shamt,
  output logic [FN_W-1:0]            Func,
  output logic [IMM_W-1:0]           Imm16,
  output logic [EXT_W-1:0]           Imm32_S,
  output logic [EXT_W-1:0]           Imm32_Z,
  output logic [ADDR_W-1:0]          Addr26,
  output logic [PC_W-1:0]            PC_Out,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INST_W-1:0] mem_w  [DEPTH];
  logic [PC_W-1:0]   mem_pc [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  // Ready/valid come only from cnt: no path from In_Valid/Out_Ready.
  assign In_Ready  = (cnt != FULL);
  assign Out_Valid = (cnt != '0);
  assign Count     = cnt;

  assign push = In_Valid & In_Ready;
  assign pop  = Out_Valid & Out_Ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (Flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage is not reset; only slots below cnt are ever observed.
  always_ff @(posedge clk) begin
    if (push && !Flush) begin
      mem_w[wptr]  <= Data;
      mem_pc[wptr] <= PC_In;
    end
  end

  assign PC_Out = Out_Valid ? mem_pc[rptr] : '0;

  ir_field_decode u_dec (
    .word    (mem_w[rptr]),
    .valid   (Out_Valid),
    .op_code (OP_Code),
    .rs      (Rs),
    .rt      (Rt),
    .rd      (Rd),
    .shamt   (Shamt),
    .func    (Func),
    .imm16   (Imm16),
    .imm32_s (Imm32_S),
    .imm32_z (Imm32_Z),
    .addr26  (Addr26)
  );

endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed table-driven bench for ir_queue
// plus streaming, flush and asynchronous reset sequences.
module tb_ir_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Data;
  logic [31:0] PC_In;
  logic        Flush;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [5:0]  OP_Code;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Shamt;
  logic [5:0]  Func;
  logic [15:0] Imm16;
  logic [31:0] Imm32_S;
  logic [31:0] Imm32_Z;
  logic [25:0] Addr26;
  logic [31:0] PC_Out;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ir_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Data      (Data),
    .PC_In     (PC_In),
    .Flush     (Flush),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .OP_Code   (OP_Code),
    .Rs        (Rs),
    .Rt        (Rt),
    .Rd        (Rd),
    .Shamt     (Shamt),
    .Func      (Func),
    .Imm16     (Imm16),
    .Imm32_S   (Imm32_S),
    .Imm32_Z   (Imm32_Z),
    .Addr26    (Addr26),
    .PC_Out    (PC_Out),
    .Count     (Count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    int          ecnt;
    logic [31:0] ew;
    logic [31:0] epc;
  } vec_t;

  vec_t tv [17];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected head fields from an independently sliced word.
  task automatic check_head(input string nm, input logic [31:0] w,
                            input logic [31:0] pc);
    logic [15:0] im;
    im = w[15:0];
    check({nm, ".op"},    32'(OP_Code), 32'(w[31:26]));
    check({nm, ".rs"},    32'(Rs),      32'(w[25:21]));
    check({nm, ".rt"},    32'(Rt),      32'(w[20:16]));
    check({nm, ".rd"},    32'(Rd),      32'(w[15:11]));
    check({nm, ".sh"},    32'(Shamt),   32'(w[10:6]));
    check({nm, ".fn"},    32'(Func),    32'(w[5:0]));
    check({nm, ".imm"},   32'(Imm16),   32'(im));
    check({nm, ".imm_s"}, Imm32_S,      {{16{im[15]}}, im});
    check({nm, ".imm_z"}, Imm32_Z,      {16'h0000, im});
    check({nm, ".a26"},   32'(Addr26),  32'(w[25:0]));
    check({nm, ".pc"},    PC_Out,       pc);
  endtask

  task automatic drive(input logic iv, input logic [31:0] d,
                       input logic [31:0] pc, input logic ordy,
                       input logic fl);
    In_Valid  = iv;
    Data      = d;
    PC_In     = pc;
    Out_Ready = ordy;
    Flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sw(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0041;
  endfunction

  function automatic logic [31:0] spc(input int i);
    return 32'h0040_1000 + 32'(i) * 32'd4;
  endfunction

  initial begin
    tv[0]  = '{1, 32'h8C430004, 32'h00400000, 0, 0,
               1, 1, 1, 32'h8C430004, 32'h00400000};
    tv[1]  = '{1, 32'h2001FFFF, 32'h00400004, 0, 0,
               1, 1, 2, 32'h8C430004, 32'h00400000};
    tv[2]  = '{1, 32'h08100000, 32'h00400008, 0, 0,
               1, 1, 3, 32'h8C430004, 32'h00400000};
    tv[3]  = '{1, 32'h00221820, 32'h0040000C, 0, 0,
               1, 0, 4, 32'h8C430004, 32'h00400000};
    tv[4]  = '{1, 32'hDEADBEEF, 32'h00400010, 0, 0,
               1, 0, 4, 32'h8C430004, 32'h00400000};
    tv[5]  = '{0, 32'h0, 32'h0, 1, 0,
               1, 1, 3, 32'h2001FFFF, 32'h00400004};
    tv[6]  = '{0, 32'h0, 32'h0, 1, 0,
               1, 1, 2, 32'h08100000, 32'h00400008};
    tv[7]  = '{1, 32'h3C01ABCD, 32'h00400014, 1, 0,
               1, 1, 2, 32'h00221820, 32'h0040000C};
    tv[8]  = '{0, 32'h0, 32'h0, 1, 0,
               1, 1, 1, 32'h3C01ABCD, 32'h00400014};
    tv[9]  = '{0, 32'h0, 32'h0, 1, 0,
               0, 1, 0, 32'h0, 32'h0};
    tv[10] = '{1, 32'h8C430004, 32'h00500000, 0, 0,
               1, 1, 1, 32'h8C430004, 32'h00500000};
    tv[11] = '{1, 32'hAC620008, 32'h00500004, 0, 0,
               1, 1, 2, 32'h8C430004, 32'h00500000};
    tv[12] = '{1, 32'h1062FFFD, 32'h00500008, 0, 0,
               1, 1, 3, 32'h8C430004, 32'h00500000};
    tv[13] = '{1, 32'h12345678, 32'h0050000C, 0, 1,
               0, 1, 0, 32'h0, 32'h0};
    tv[14] = '{1, 32'h00221820, 32'h00500010, 0, 0,
               1, 1, 1, 32'h00221820, 32'h00500010};
    tv[15] = '{0, 32'h0, 32'h0, 1, 0,
               0, 1, 0, 32'h0, 32'h0};
    tv[16] = '{0, 32'h0, 32'h0, 1, 0,
               0, 1, 0, 32'h0, 32'h0};

    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst.ov",  32'(Out_Valid), 32'd0);
    check("rst.ir",  32'(In_Ready),  32'd1);
    check("rst.cnt", 32'(Count),     32'd0);
    check_head("rst", 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i].iv, tv[i].d, tv[i].pc, tv[i].ordy, tv[i].fl);
      step();
      check($sformatf("v%0d.ov", i),  32'(Out_Valid), 32'(tv[i].eov));
      check($sformatf("v%0d.ir", i),  32'(In_Ready),  32'(tv[i].eir));
      check($sformatf("v%0d.cnt", i), 32'(Count),     32'(tv[i].ecnt));
      check_head($sformatf("v%0d", i), tv[i].ew, tv[i].epc);
      if (i == 0) begin
        check("lw.op",   32'(OP_Code), 32'h23);
        check("lw.rs",   32'(Rs),      32'd2);
        check("lw.rt",   32'(Rt),      32'd3);
        check("lw.imms", Imm32_S,      32'h00000004);
      end
      if (i == 5) begin
        check("addi.imms", Imm32_S, 32'hFFFFFFFF);
        check("addi.immz", Imm32_Z, 32'h0000FFFF);
      end
      if (i == 6) begin
        check("j.a26", 32'(Addr26), 32'h0100000);
      end
    end

    // Streaming at Count=2: one in and one out every cycle.
    @(negedge clk);
    drive(1, sw(0), spc(0), 0, 0);
    step();
    @(negedge clk);
    drive(1, sw(1), spc(1), 0, 0);
    step();
    check("st.pre.cnt", 32'(Count), 32'd2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1, sw(i + 2), spc(i + 2), 1, 0);
      check_head($sformatf("st%0d", i), sw(i), spc(i));
      step();
      check($sformatf("st%0d.cnt", i), 32'(Count), 32'd2);
    end
    for (int i = 12; i < 14; i++) begin
      @(negedge clk);
      drive(0, 32'h0, 32'h0, 1, 0);
      check_head($sformatf("dr%0d", i), sw(i), spc(i));
      step();
    end
    check("dr.cnt", 32'(Count), 32'd0);
    check("dr.ov",  32'(Out_Valid), 32'd0);

    // Asynchronous reset between edges.
    @(negedge clk);
    drive(1, 32'h8C430004, 32'h00600000, 0, 0);
    step();
    @(negedge clk);
    drive(1, 32'hAC620008, 32'h00600004, 0, 0);
    step();
    check("ar.pre.cnt", 32'(Count), 32'd2);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("ar.ov",  32'(Out_Valid), 32'd0);
    check("ar.ir",  32'(In_Ready),  32'd1);
    check("ar.cnt", 32'(Count),     32'd0);
    check("ar.pc",  PC_Out,         32'h0);
    check("ar.op",  32'(OP_Code),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h2001FFFF, 32'h00700000, 0, 0);
    step();
    check("ar.post.cnt", 32'(Count), 32'd1);
    check_head("ar.post", 32'h2001FFFF, 32'h00700000);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
